// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready output register with frame-error and overrun pulses.
module uart_rx_8n1 #(
    parameter int unsigned CLK_DIV = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             rx_meta_q, rx_s_q;
    logic             frame_done_c;

    // Next-state, bit sampling and output-register update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        frame_done_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d        = '0;
                    frame_done_c = rx_s_q;
                    frame_err_d  = !rx_s_q;
                    state_d      = rx_s_q ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A completed byte lands only if the holding register is free or being drained
        if (frame_done_c) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_meta_q   <= rx_i;
            rx_s_q      <= rx_meta_q;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed plus randomized bench for uart_rx_8n1; a negedge monitor collects
// delivered bytes and pulses, the main sequence compares them to expectations.
module tb_uart_rx_8n1;

    localparam int unsigned CLK_DIV = 32;
    localparam int unsigned LAT     = 2 + CLK_DIV / 2 + 9 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 1;   // 0: low, 1: high, 2: toggle every cycle

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready_i = 1'b0;
            1:       ready_i = 1'b1;
            default: ready_i = ~ready_i;
        endcase
    end

    // Monitor: delivered bytes, pulse counts and protocol properties
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    int fe_cnt = 0, ov_cnt = 0, ov_cyc = 0, rise_cyc = 0, cur_len = 0, last_len = 0;
    int pulse_viol = 0, stab_viol = 0;
    logic prev_valid = 0, prev_ready = 0, prev_fe = 0, prev_ov = 0, prev_rst = 1;
    logic [7:0] prev_data = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) acc_q.push_back(data_o);
            if (valid_o && !prev_valid) rise_cyc = cyc;
            if (valid_o) cur_len++;
            else begin
                if (prev_valid) last_len = cur_len;
                cur_len = 0;
            end
            if (frame_err_o) fe_cnt++;
            if (overrun_o) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            if ((frame_err_o && overrun_o) || (frame_err_o && prev_fe) || (overrun_o && prev_ov))
                pulse_viol++;
            if (prev_valid && !prev_ready && !prev_rst && data_o !== prev_data) stab_viol++;
        end
        prev_valid = valid_o;
        prev_ready = ready_i;
        prev_fe    = frame_err_o;
        prev_ov    = overrun_o;
        prev_rst   = rst;
        prev_data  = data_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp);
        checks++;
        assert (obs >= exp - 1 && obs <= exp + 1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d(+-1)", tag, obs, exp);
        end
    endtask

    task automatic check_acc(input string tag);
        check({tag, "_count"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, 32'(acc_q[i]), 32'(exp_q[i]));
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; rst_bit selects the bit slot (0=start .. 9=stop) that gets a mid-bit reset pulse
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
        for (int i = 0; i < 10; i++) begin
            logic bv;
            bv = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            rx_i = bv;
            if (i == rst_bit) begin
                wait_cyc(CLK_DIV / 2);
                rst = 1'b1;
                wait_cyc(1);
                rst = 1'b0;
                wait_cyc(CLK_DIV - CLK_DIV / 2 - 1);
            end else begin
                wait_cyc(CLK_DIV);
            end
        end
    endtask

    initial begin
        int c0, c1, fe0, ov0;
        logic [7:0] rb;
        logic rs;

        rst  = 1'b1;
        rx_i = 1'b1;
        wait_cyc(3);
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_ferr", 32'(frame_err_o), 0);
        check("rst_ovr", 32'(overrun_o), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Single byte, latency and pulse width
        c0 = cyc;
        send_frame(8'h65, 1'b1, -1);
        exp_q.push_back(8'h65);
        wait_cyc(40);
        check_acc("b65");
        check_near("b65_latency", rise_cyc - c0, LAT);
        check("b65_valid_len", last_len, 1);
        check("b65_ferr", fe_cnt, 0);
        check("b65_ovr", ov_cnt, 0);

        // Short low glitch is rejected at the mid-start check
        fe0 = fe_cnt;
        rx_i = 1'b0;
        wait_cyc(10);
        rx_i = 1'b1;
        wait_cyc(60);
        check_acc("glitch");
        send_frame(8'h3C, 1'b1, -1);
        exp_q.push_back(8'h3C);
        wait_cyc(40);
        check_acc("b3c");
        check("glitch_ferr", fe_cnt, fe0);

        // Bad stop bit followed by a long break
        send_frame(8'hA5, 1'b0, -1);
        wait_cyc(500);
        rx_i = 1'b1;
        wait_cyc(40);
        check("break_ferr", fe_cnt, fe0 + 1);
        check_acc("break");
        send_frame(8'h5A, 1'b1, -1);
        exp_q.push_back(8'h5A);
        wait_cyc(40);
        check_acc("b5a");

        // Overrun with the consumer stalled
        ready_mode = 0;
        wait_cyc(2);
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1);
        c1 = cyc;
        send_frame(8'h22, 1'b1, -1);
        wait_cyc(40);
        check("ovr_valid", 32'(valid_o), 1);
        check("ovr_data", 32'(data_o), 32'h11);
        check("ovr_count", ov_cnt, ov0 + 1);
        check_near("ovr_cycle", ov_cyc - c1, LAT);
        check("ovr_none_taken", acc_q.size(), 0);
        ready_mode = 1;
        for (int k = 0; k < 5 && !ready_i; k++) @(negedge clk);
        check("ovr_ready_seen", 32'(ready_i), 1);
        check("ovr_valid_before", 32'(valid_o), 1);
        @(negedge clk);
        check("ovr_valid_fall", 32'(valid_o), 0);
        wait_cyc(1);
        exp_q.push_back(8'h11);
        check_acc("ovr");

        // Reset pulse during data bit 4 aborts the frame silently
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'hF3, 1'b1, 5);
        wait_cyc(40);
        check("midrst_valid", 32'(valid_o), 0);
        check("midrst_data", 32'(data_o), 32'h00);
        check("midrst_ferr", fe_cnt, fe0);
        check("midrst_ovr", ov_cnt, ov0);
        check_acc("midrst");
        send_frame(8'hFF, 1'b1, -1);
        exp_q.push_back(8'hFF);
        wait_cyc(40);
        check_acc("bff");

        // Back-to-back 0x00/0xFF stream with a toggling consumer
        ready_mode = 2;
        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) begin
            rb = (i % 2 == 1) ? 8'hFF : 8'h00;
            send_frame(rb, 1'b1, -1);
            exp_q.push_back(rb);
        end
        wait_cyc(40);
        check_acc("stream");
        check("stream_ovr", ov_cnt, ov0);

        // Random bytes, occasional bad stop bits
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        c0 = 0;
        for (int i = 0; i < 10; i++) begin
            ready_mode = int'($urandom_range(1, 2));
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, -1);
            if (rs) exp_q.push_back(rb);
            else begin
                c0++;
                rx_i = 1'b1;
                wait_cyc(CLK_DIV);
            end
        end
        rx_i = 1'b1;
        wait_cyc(40);
        check_acc("rand");
        check("rand_ferr", fe_cnt, fe0 + c0);
        check("rand_ovr", ov_cnt, ov0);

        check("pulse_rules", pulse_viol, 0);
        check("data_stable", stab_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
